scan_chain_sequencer: RTL

// - Drives the daisy-chained scanchain slots from one clock: captures every slot's module outputs, then shifts new inputs into one selected slot.
// - Extracts that slot's captured outputs from the chain return, latches inputs into all slots and reports completion.
// - Sits between the chip pads/host logic and the first scanchain; the chain return comes back on scan_data_in.

---
 rtl/scan_chain_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/scan_chain_sequencer.sv
// scan_chain_sequencer: captures all scanchain slots, shifts new inputs into one slot, extracts its outputs, latches
// Ports: clk/reset_n; go, active_select, inputs -> frame request; outputs/ready/busy -> host;
//   scan_clk_out/scan_data_out/scan_select/scan_latch_en/scan_data_in -> chain; la_* -> host override.
// Optional feature: define LA_SCAN_OVERRIDE_EN to let the host drive the chain directly while idle.
module scan_chain_sequencer #(
  parameter int NUM_DESIGNS = 250,
  parameter int NUM_IOS     = 8,
  parameter int HALF_PERIOD = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               go,
  input  logic [8:0]         active_select,
  input  logic [NUM_IOS-1:0] inputs,
  output logic [NUM_IOS-1:0] outputs,
  output logic               ready,
  output logic               busy,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select,
  output logic               scan_latch_en,
  input  logic               scan_data_in,
  input  logic               la_mode,
  input  logic               la_scan_clk_in,
  input  logic               la_scan_data_in,
  input  logic               la_scan_select,
  input  logic               la_scan_latch_en,
  output logic               la_scan_data_out
);
  localparam int P  = NUM_DESIGNS * NUM_IOS;
  localparam int CW = $clog2(P + 1);
  localparam int PW = $clog2(2 * HALF_PERIOD) > 0 ? $clog2(2 * HALF_PERIOD) : 1;
  localparam int BW = NUM_IOS > 1 ? $clog2(NUM_IOS) : 1;
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_LATCH, S_DONE} state_t;
  state_t             r_state, w_next;
  logic [PW-1:0]      r_ph;
  logic [CW-1:0]      r_cnt;
  logic [8:0]         r_sel;
  logic [NUM_IOS-1:0] r_in, r_shadow, r_out;
  logic               w_bit_end, w_high, w_sample, w_hit, w_la_block;
  logic               w_sclk, w_sdo;
  logic [31:0]        w_u, w_base, w_off;
  logic [BW-1:0]      w_bi;
  // r_ph walks one scan bit: low phase first, then high phase
  assign w_bit_end = r_ph == PW'(2 * HALF_PERIOD - 1);
  assign w_high    = r_ph >= PW'(HALF_PERIOD);
  assign w_sample  = r_ph == PW'(HALF_PERIOD - 1);
  // Bit shifted at index t lands at chain position u = P-1-t = slot*NUM_IOS + bit
  assign w_u    = 32'(P - 1) - 32'(r_cnt);
  assign w_base = 32'(r_sel) * 32'(NUM_IOS);
  assign w_off  = w_u - w_base;
  assign w_hit  = (32'(r_sel) < 32'(NUM_DESIGNS)) && (w_u >= w_base) && (w_off < 32'(NUM_IOS));
  assign w_bi   = w_off[BW-1:0];
  assign w_sclk = (r_state == S_CAPTURE || r_state == S_SHIFT) && w_high;
  assign w_sdo  = (r_state == S_SHIFT) && w_hit && r_in[w_bi];
  assign outputs          = r_out;
  assign ready            = r_state == S_DONE;
  assign busy             = r_state == S_CAPTURE || r_state == S_SHIFT || r_state == S_LATCH;
  assign la_scan_data_out = scan_data_in;
`ifdef LA_SCAN_OVERRIDE_EN
  logic w_ovr;
  assign w_la_block    = la_mode;
  assign w_ovr         = la_mode && r_state == S_IDLE && reset_n;
  assign scan_clk_out  = w_ovr ? la_scan_clk_in   : w_sclk;
  assign scan_data_out = w_ovr ? la_scan_data_in  : w_sdo;
  assign scan_select   = w_ovr ? la_scan_select   : r_state == S_CAPTURE;
  assign scan_latch_en = w_ovr ? la_scan_latch_en : r_state == S_LATCH;
`else
  logic w_unused;
  assign w_la_block    = 1'b0;
  assign w_unused      = ^{la_mode, la_scan_clk_in, la_scan_data_in, la_scan_select, la_scan_latch_en};
  assign scan_clk_out  = w_sclk;
  assign scan_data_out = w_sdo;
  assign scan_select   = r_state == S_CAPTURE;
  assign scan_latch_en = r_state == S_LATCH;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = (go && !w_la_block) ? S_CAPTURE : S_IDLE;
      S_CAPTURE: w_next = w_bit_end ? S_SHIFT : S_CAPTURE;
      S_SHIFT:   w_next = (w_bit_end && r_cnt == CW'(P - 1)) ? S_LATCH : S_SHIFT;
      S_LATCH:   w_next = w_bit_end ? S_DONE : S_LATCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ph     <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_in     <= '0;
      r_shadow <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_next;
      r_ph    <= (r_state == S_IDLE || w_bit_end) ? '0 : r_ph + 1'b1;
      if (r_state == S_IDLE && w_next == S_CAPTURE) begin
        r_sel    <= active_select;
        r_in     <= inputs;
        r_shadow <= '0;
        r_cnt    <= '0;
      end
      if (r_state == S_SHIFT && w_sample && w_hit) r_shadow[w_bi] <= scan_data_in;
      if (r_state == S_SHIFT && w_bit_end) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_LATCH && w_bit_end) r_out <= r_shadow;
    end
  end
endmodule
